// File: rtl/vga_timing_pkg.sv
// Shared 800x480 LCD/VGA timing defaults, counter widths and receiver states.
// Used by the sync receiver and its stage-1 edge detector.
package vga_timing_pkg;

    localparam int H_TOTAL  = 1056;
    localparam int V_TOTAL  = 525;
    localparam int H_START  = 46;
    localparam int H_ACTIVE = 800;
    localparam int V_START  = 23;
    localparam int V_ACTIVE = 480;
    localparam int HS_WIDTH = 30;
    localparam int VS_WIDTH = 13;

    localparam int HW = 11;
    localparam int VW = 10;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_rx_edge.sv
// Stage-1 pin register with HS/VS falling-edge detect.
// Sync regs reset high so release from reset never looks like an edge.
module vga_rx_edge
    import vga_timing_pkg::*;
(
    input  logic iCLK,
    input  logic iRSTN,
    input  logic hs_pin,
    input  logic vs_pin,
    input  rgb_t rgb_pin,
    output logic hs_fall,
    output logic vs_fall,
    output rgb_t rgb
);

    logic hs_q;
    logic vs_q;
    logic hs_d;
    logic vs_d;

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            hs_d <= 1'b1;
            vs_d <= 1'b1;
            rgb  <= '0;
        end else begin
            hs_q <= hs_pin;
            vs_q <= vs_pin;
            hs_d <= hs_q;
            vs_d <= vs_q;
            rgb  <= rgb_pin;
        end
    end

    assign hs_fall = hs_d & ~hs_q;
    assign vs_fall = vs_d & ~vs_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// Sync receiver: measures line/frame periods, locks, emits pixel coordinates.
// Optional frame checksum ports under VGA_RX_CHECKSUM_EN.
module vga_sync_receiver #(
    parameter int H_TOTAL  = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL  = vga_timing_pkg::V_TOTAL,
    parameter int H_START  = vga_timing_pkg::H_START,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int V_START  = vga_timing_pkg::V_START,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE
) (
    input  logic        iCLK,
    input  logic        iRSTN,
    input  logic        iVGA_HS,
    input  logic        iVGA_VS,
    input  logic [7:0]  iVGA_R,
    input  logic [7:0]  iVGA_G,
    input  logic [7:0]  iVGA_B,
    output logic        oWR,
    output logic [10:0] oX,
    output logic [9:0]  oY,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic        oSOF,
    output logic        oLOCKED,
    output logic [10:0] oH_MEAS,
    output logic [9:0]  oV_MEAS,
    output logic [7:0]  oERR_CNT
`ifdef VGA_RX_CHECKSUM_EN
    ,
    output logic [31:0] oFRAME_SUM,
    output logic        oSUM_VALID
`endif
);

    import vga_timing_pkg::*;

    localparam logic [HW-1:0] HT  = HW'(H_TOTAL);
    localparam logic [HW-1:0] HS0 = HW'(H_START);
    localparam logic [HW-1:0] HS1 = HW'(H_START + H_ACTIVE - 1);
    localparam logic [VW-1:0] VT  = VW'(V_TOTAL);
    localparam logic [VW-1:0] VS0 = VW'(V_START);
    localparam logic [VW-1:0] VS1 = VW'(V_START + V_ACTIVE - 1);

    rgb_t pin_rgb;
    rgb_t pix;
    logic hs_fall;
    logic vs_fall;

    assign pin_rgb = {iVGA_R, iVGA_G, iVGA_B};

    vga_rx_edge u_edge (
        .iCLK    (iCLK),
        .iRSTN   (iRSTN),
        .hs_pin  (iVGA_HS),
        .vs_pin  (iVGA_VS),
        .rgb_pin (pin_rgb),
        .hs_fall (hs_fall),
        .vs_fall (vs_fall),
        .rgb     (pix)
    );

    rx_state_t     state;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          vs_pend;
    logic          h_seen;
    logic          v_seen;
    logic          frame_ok;

    logic line0;
    logic h_len_ok;
    logic v_len_ok;
    logic h_over;
    logic lose;
    logic qualify;
    logic measure_fail;
    logic lock_next;
    logic active;
    logic wr_next;

    // A VS fall in the same cycle as the HS fall also starts line 0.
    assign line0    = hs_fall & (vs_pend | vs_fall);
    assign h_len_ok = (h_cnt + 1'b1) == HT;
    assign v_len_ok = (v_cnt + 1'b1) == VT;
    assign h_over   = h_cnt == HT;

    assign lose = (state == LOCKED) &
                  ((hs_fall & ~h_len_ok) |
                   (~hs_fall & h_over) |
                   (line0 & ~v_len_ok));

    assign qualify = (state == MEASURE) & line0 & frame_ok &
                     h_len_ok & v_len_ok;
    assign measure_fail = (state == MEASURE) & line0 & ~qualify;
    assign lock_next = qualify | ((state == LOCKED) & ~lose);

    assign active = (h_cnt >= HS0) && (h_cnt <= HS1) &&
                    (v_cnt >= VS0) && (v_cnt <= VS1);
    assign wr_next = active & lock_next;

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            vs_pend <= 1'b0;
            h_seen  <= 1'b0;
            v_seen  <= 1'b0;
            oH_MEAS <= '0;
            oV_MEAS <= '0;
        end else begin
            if (hs_fall) begin
                h_cnt  <= '0;
                h_seen <= 1'b1;
                if (h_seen) oH_MEAS <= h_cnt + 1'b1;
            end else if (h_cnt != '1) begin
                h_cnt <= h_cnt + 1'b1;
            end
            if (line0) begin
                v_cnt  <= '0;
                v_seen <= 1'b1;
                if (v_seen) oV_MEAS <= v_cnt + 1'b1;
            end else if (hs_fall && v_cnt != '1) begin
                v_cnt <= v_cnt + 1'b1;
            end
            if (hs_fall) vs_pend <= 1'b0;
            else if (vs_fall) vs_pend <= 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state    <= SEARCH;
            frame_ok <= 1'b0;
            oLOCKED  <= 1'b0;
            oERR_CNT <= '0;
        end else begin
            oLOCKED <= lock_next;
            if ((lose || measure_fail) && oERR_CNT != 8'hFF)
                oERR_CNT <= oERR_CNT + 8'd1;
            unique case (state)
                SEARCH: begin
                    if (line0) begin
                        state    <= MEASURE;
                        frame_ok <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (line0) begin
                        state    <= qualify ? LOCKED : MEASURE;
                        frame_ok <= 1'b1;
                    end else if (hs_fall && !h_len_ok) begin
                        frame_ok <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (lose) state <= SEARCH;
                end
                default: state <= SEARCH;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            oWR  <= 1'b0;
            oSOF <= 1'b0;
            oX   <= '0;
            oY   <= '0;
            oR   <= '0;
            oG   <= '0;
            oB   <= '0;
        end else begin
            oWR  <= wr_next;
            oSOF <= wr_next && (h_cnt == HS0) && (v_cnt == VS0);
            if (wr_next) begin
                oX <= h_cnt - HS0;
                oY <= v_cnt - VS0;
                oR <= pix.r;
                oG <= pix.g;
                oB <= pix.b;
            end
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [31:0] acc;
    logic        sum_pend;

    always_ff @(posedge iCLK or negedge iRSTN) begin
        if (!iRSTN) begin
            acc        <= '0;
            sum_pend   <= 1'b0;
            oFRAME_SUM <= '0;
            oSUM_VALID <= 1'b0;
        end else begin
            sum_pend   <= 1'b0;
            oSUM_VALID <= sum_pend;
            if (lose) begin
                acc <= '0;
            end else if (state == LOCKED && line0) begin
                oFRAME_SUM <= acc;
                sum_pend   <= 1'b1;
                acc        <= '0;
            end else if (wr_next) begin
                acc <= acc + 32'(pix.r) + 32'(pix.g) + 32'(pix.b);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a reduced timing so frames stay short.
// Source drives R=x, G=y, B=x+y; a scoreboard checks every oWR.
module tb_vga_sync_receiver;

    localparam int HT    = 64;
    localparam int VT    = 20;
    localparam int HST   = 10;
    localparam int HA    = 40;
    localparam int VST   = 3;
    localparam int VA    = 12;
    localparam int HSW   = 6;
    localparam int VSW   = 2;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [10:0] px;
        logic [9:0]  py;
        logic [7:0]  pr;
        logic [7:0]  pg;
        logic [7:0]  pb;
    } px_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        hs    = 1'b1;
    logic        vs    = 1'b1;
    logic [7:0]  r     = '0;
    logic [7:0]  g     = '0;
    logic [7:0]  b     = '0;
    logic        wr;
    logic [10:0] x_o;
    logic [9:0]  y_o;
    logic [7:0]  r_o;
    logic [7:0]  g_o;
    logic [7:0]  b_o;
    logic        sof;
    logic        locked;
    logic [10:0] h_meas;
    logic [9:0]  v_meas;
    logic [7:0]  err_cnt;
`ifdef VGA_RX_CHECKSUM_EN
    logic [31:0] frame_sum;
    logic        sum_valid;
`endif

    always #5 clk = ~clk;

    vga_sync_receiver #(
        .H_TOTAL  (HT),
        .V_TOTAL  (VT),
        .H_START  (HST),
        .H_ACTIVE (HA),
        .V_START  (VST),
        .V_ACTIVE (VA)
    ) dut (
        .iCLK     (clk),
        .iRSTN    (rst_n),
        .iVGA_HS  (hs),
        .iVGA_VS  (vs),
        .iVGA_R   (r),
        .iVGA_G   (g),
        .iVGA_B   (b),
        .oWR      (wr),
        .oX       (x_o),
        .oY       (y_o),
        .oR       (r_o),
        .oG       (g_o),
        .oB       (b_o),
        .oSOF     (sof),
        .oLOCKED  (locked),
        .oH_MEAS  (h_meas),
        .oV_MEAS  (v_meas),
        .oERR_CNT (err_cnt)
`ifdef VGA_RX_CHECKSUM_EN
        ,
        .oFRAME_SUM (frame_sum),
        .oSUM_VALID (sum_valid)
`endif
    );

    int  checks = 0;
    int  passed = 0;
    int  hpos = 0;
    int  vline = 10;
    int  line_len = HT;
    int  step_n = 0;
    int  starts = 0;
    int  last_fall = 0;
    bit  hs_off = 1'b0;
    bit  short_next = 1'b0;
    bit  sb_en = 1'b0;
    px_t sb[$];

    logic        ob_wr = 1'b0;
    logic        ob_sof = 1'b0;
    logic        ob_lock = 1'b0;
    logic [10:0] ob_x;
    logic [9:0]  ob_y;
    logic [7:0]  ob_r;
    logic [7:0]  ob_g;
    logic [7:0]  ob_b;
    logic [10:0] ob_hm;
    logic [9:0]  ob_vm;
    logic [7:0]  ob_err;

    // One pixel clock: sample outputs, drive next source pixel, advance.
    task automatic step();
        int  x;
        int  y;
        bit  act;
        px_t e;
        @(negedge clk);
        ob_wr   = wr;
        ob_sof  = sof;
        ob_lock = locked;
        ob_x    = x_o;
        ob_y    = y_o;
        ob_r    = r_o;
        ob_g    = g_o;
        ob_b    = b_o;
        ob_hm   = h_meas;
        ob_vm   = v_meas;
        ob_err  = err_cnt;
        act = hpos > HST && hpos <= HST + HA &&
              vline >= VST && vline < VST + VA;
        x  = hpos - HST - 1;
        y  = vline - VST;
        hs = hs_off || hpos >= HSW;
        vs = vline >= VSW;
        r  = act ? 8'(x) : 8'd0;
        g  = act ? 8'(y) : 8'd0;
        b  = act ? 8'(x + y) : 8'd0;
        if (act && sb_en) begin
            e.px = 11'(x);
            e.py = 10'(y);
            e.pr = 8'(x);
            e.pg = 8'(y);
            e.pb = 8'(x + y);
            sb.push_back(e);
        end
        if (hpos == 0 && !hs_off) last_fall = step_n;
        if (hpos == 0 && vline == 0) starts++;
        step_n++;
        if (hpos == line_len - 1) begin
            hpos = 0;
            line_len = short_next ? HT - 1 : HT;
            short_next = 1'b0;
            vline = (vline == VT - 1) ? 0 : vline + 1;
        end else begin
            hpos++;
        end
    endtask

    task automatic goto_pos(input int v, input int h);
        int n = 0;
        while (!(vline == v && hpos == h) && n < 2 * FRAME) begin
            step();
            n++;
        end
    endtask

    task automatic wait_lock(output int ns, output int bw, output int nsof);
        int s0 = starts;
        int n = 0;
        bw = 0;
        nsof = 0;
        while (!ob_lock && n < 4 * FRAME) begin
            step();
            n++;
            if (ob_wr && !ob_lock) bw++;
            if (ob_sof) nsof++;
        end
        ns = starts - s0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (ob_wr !== 1'b0) $display("FAIL rst_wr got %b want 0", ob_wr);
        else passed++;
        checks++;
        if (ob_lock !== 1'b0) $display("FAIL rst_lock got %b want 0", ob_lock);
        else passed++;
        checks++;
        if (ob_err !== 8'd0) $display("FAIL rst_err got %0d want 0", ob_err);
        else passed++;
        checks++;
        if ({ob_hm, ob_vm} !== 21'd0)
            $display("FAIL rst_meas got %0d/%0d want 0/0", ob_hm, ob_vm);
        else passed++;
        checks++;
        if ({ob_x, ob_y, ob_sof} !== 22'd0)
            $display("FAIL rst_xy got %0d/%0d/%b want 0", ob_x, ob_y, ob_sof);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        int ns, bw, nsof;
        int bad = 0;
        int wrs = 0;
        int sofs = 0;
        px_t e;
`ifdef VGA_RX_CHECKSUM_EN
        int pulses = 0;
        longint exp_sum = 0;
        for (int yy = 0; yy < VA; yy++)
            for (int xx = 0; xx < HA; xx++)
                exp_sum += xx + yy + ((xx + yy) & 255);
`endif
        wait_lock(ns, bw, nsof);
        checks++;
        if (ob_lock !== 1'b1) $display("FAIL nom_lock got %b want 1", ob_lock);
        else passed++;
        checks++;
        if (ns !== 2) $display("FAIL nom_lock_starts got %0d want 2", ns);
        else passed++;
        goto_pos(0, 0);
        sb_en = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (ob_sof) sofs++;
`ifdef VGA_RX_CHECKSUM_EN
            if (sum_valid) pulses++;
`endif
            if (ob_wr) begin
                wrs++;
                if (sb.size() == 0) begin
                    bad++;
                end else begin
                    e = sb.pop_front();
                    if ({ob_x, ob_y, ob_r, ob_g, ob_b} !== e) bad++;
                end
            end
        end
        sb_en = 1'b0;
        repeat (4) step();
        checks++;
        if (bad !== 0) $display("FAIL nom_pixels got %0d bad want 0", bad);
        else passed++;
        checks++;
        if (wrs !== 2 * HA * VA)
            $display("FAIL nom_wr_count got %0d want %0d", wrs, 2 * HA * VA);
        else passed++;
        checks++;
        if (sofs !== 2) $display("FAIL nom_sof got %0d want 2", sofs);
        else passed++;
        checks++;
        if (sb.size() !== 0) $display("FAIL nom_sb_left got %0d want 0", sb.size());
        else passed++;
        checks++;
        if (ob_hm !== 11'(HT)) $display("FAIL nom_hmeas got %0d want %0d", ob_hm, HT);
        else passed++;
        checks++;
        if (ob_vm !== 10'(VT)) $display("FAIL nom_vmeas got %0d want %0d", ob_vm, VT);
        else passed++;
        checks++;
        if (ob_err !== 8'd0) $display("FAIL nom_err got %0d want 0", ob_err);
        else passed++;
`ifdef VGA_RX_CHECKSUM_EN
        checks++;
        if (pulses !== 2) $display("FAIL sum_pulses got %0d want 2", pulses);
        else passed++;
        checks++;
        if (frame_sum !== 32'(exp_sum))
            $display("FAIL frame_sum got %0d want %0d", frame_sum, exp_sum);
        else passed++;
`endif
    endtask

    task automatic test_short_line();
        int ns, bw, nsof;
        goto_pos(8, 30);
        short_next = 1'b1;
        goto_pos(10, 1);
        step();
        checks++;
        if (ob_lock !== 1'b1) $display("FAIL short_pre got %b want 1", ob_lock);
        else passed++;
        step();
        checks++;
        if ({ob_lock, ob_wr} !== 2'b00)
            $display("FAIL short_drop got %b%b want 00", ob_lock, ob_wr);
        else passed++;
        checks++;
        if (ob_err !== 8'd1) $display("FAIL short_err got %0d want 1", ob_err);
        else passed++;
        wait_lock(ns, bw, nsof);
        checks++;
        if (ns !== 2 || ob_lock !== 1'b1)
            $display("FAIL short_relock got %0d/%b want 2/1", ns, ob_lock);
        else passed++;
        checks++;
        if (bw !== 0) $display("FAIL short_wr_unlocked got %0d want 0", bw);
        else passed++;
        checks++;
        if (ob_err !== 8'd1) $display("FAIL short_err_hold got %0d want 1", ob_err);
        else passed++;
    endtask

    task automatic test_hs_loss();
        int ns, bw, nsof;
        int f;
        int n = 0;
        goto_pos(5, 1);
        f = last_fall;
        hs_off = 1'b1;
        while (step_n < f + HT + 2 && n < 2 * FRAME) begin
            step();
            n++;
        end
        step();
        checks++;
        if (ob_lock !== 1'b1) $display("FAIL hsloss_pre got %b want 1", ob_lock);
        else passed++;
        step();
        checks++;
        if (ob_lock !== 1'b0) $display("FAIL hsloss_drop got %b want 0", ob_lock);
        else passed++;
        checks++;
        if (ob_hm !== 11'(HT)) $display("FAIL hsloss_hmeas got %0d want %0d", ob_hm, HT);
        else passed++;
        checks++;
        if (ob_err !== 8'd2) $display("FAIL hsloss_err got %0d want 2", ob_err);
        else passed++;
        n = 0;
        while (!(step_n >= f + 150 && hpos == 20) && n < 2 * FRAME) begin
            step();
            n++;
        end
        hs_off = 1'b0;
        wait_lock(ns, bw, nsof);
        checks++;
        if (ns !== 2 || ob_lock !== 1'b1)
            $display("FAIL hsloss_relock got %0d/%b want 2/1", ns, ob_lock);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        int ns, bw, nsof;
        int n = 0;
        goto_pos(8, 20);
        checks++;
        if (ob_wr !== 1'b1) $display("FAIL mid_wr_before got %b want 1", ob_wr);
        else passed++;
        rst_n = 1'b0;
        step();
        checks++;
        if ({ob_wr, ob_lock, ob_sof, ob_err} !== 11'd0)
            $display("FAIL mid_rst_ctl got %b%b%b/%0d want 0", ob_wr, ob_lock, ob_sof, ob_err);
        else passed++;
        checks++;
        if ({ob_x, ob_y, ob_r, ob_hm, ob_vm} !== 50'd0)
            $display("FAIL mid_rst_data got %0d/%0d/%0d/%0d/%0d want 0",
                     ob_x, ob_y, ob_r, ob_hm, ob_vm);
        else passed++;
        step();
        step();
        rst_n = 1'b1;
        wait_lock(ns, bw, nsof);
        checks++;
        if (ns !== 2 || ob_lock !== 1'b1)
            $display("FAIL mid_relock got %0d/%b want 2/1", ns, ob_lock);
        else passed++;
        checks++;
        if (nsof !== 0 || bw !== 0)
            $display("FAIL mid_spurious got sof %0d wr %0d want 0", nsof, bw);
        else passed++;
        while (!ob_wr && n < FRAME) begin
            step();
            n++;
        end
        checks++;
        if ({ob_wr, ob_sof, ob_x, ob_y} !== {2'b11, 21'd0})
            $display("FAIL mid_first_px got %b%b %0d/%0d want 11 0/0",
                     ob_wr, ob_sof, ob_x, ob_y);
        else passed++;
        checks++;
        if (ob_err !== 8'd0) $display("FAIL mid_err got %0d want 0", ob_err);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_line();
        test_hs_loss();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Sink-side counterpart of the 800x480 LCD/VGA timing generator. Takes HS/VS/RGB on the pixel clock and measures line and frame periods. Locks onto the expected timing and emits pixel coordinates with a write strobe. Sits in front of frame-capture and loopback-check logic. In-domain input only: HS/VS/RGB are produced on iCLK, so there is no CDC synchronizer.

## Interface
- H_TOTAL, 1056: expected clocks per line (HS fall to HS fall)
- V_TOTAL, 525: expected lines per frame
- H_START, 46: clocks from HS fall to first active pixel
- H_ACTIVE, 800: active pixels per line
- V_START, 23: lines from frame line 0 to first active line
- V_ACTIVE, 480: active lines per frame
- iCLK  in  1  pixel clock
- iRSTN  in  1  reset, asynchronous, active-low
- iVGA_HS  in  1  horizontal sync, active-low
- iVGA_VS  in  1  vertical sync, active-low
- iVGA_R / iVGA_G / iVGA_B  in  8 each  pixel data
- oWR  out  1  active pixel valid
- oX  out  11  pixel column, 0..H_ACTIVE-1
- oY  out  10  pixel row, 0..V_ACTIVE-1
- oR / oG / oB  out  8 each  pixel data aligned with oWR
- oSOF  out  1  one-cycle pulse with the first oWR of a frame
- oLOCKED  out  1  timing matches parameters
- oH_MEAS  out  11  last measured line length
- oV_MEAS  out  10  last measured frame length (lines)
- oERR_CNT  out  8  saturating count of lock losses / failed measurements

## Operation
- Stage 1 registers all pins; edge detect uses the stage-1 and previous values. HS fall = 1→0.
- h_cnt (11 b): 0 on the stage-1 cycle of an HS fall, else +1, saturating at 2047.
- A VS fall sets vs_pend. The next HS fall, including one in the same cycle, clears vs_pend and makes that line line 0.
- v_cnt (10 b): 0 on the line-0 HS fall, +1 on other HS falls, saturating at 1023.
- On each HS fall, oH_MEAS <= h_cnt+1. On each line-0 HS fall, oV_MEAS <= v_cnt+1. Neither updates on the first fall after reset.
- FSM:
  - SEARCH: waits for the first line-0 HS fall → MEASURE.
  - MEASURE: on the next line-0 HS fall, if every line in the frame had H_TOTAL length and the frame had V_TOTAL lines → LOCKED. Otherwise increment oERR_CNT and stay in MEASURE for another frame.
  - LOCKED: any HS fall with h_cnt+1 ≠ H_TOTAL, h_cnt reaching H_TOTAL without an HS fall, or a line-0 fall with v_cnt+1 ≠ V_TOTAL → SEARCH, increment oERR_CNT.
- Active window: h_cnt in [H_START, H_START+H_ACTIVE-1] and v_cnt in [V_START, V_START+V_ACTIVE-1].
- oWR = active and state==LOCKED. oX = h_cnt-H_START. oY = v_cnt-V_START. Coordinates are don't-care when oWR=0 but held at their last value.
- oSOF = oWR with oX==0 and oY==0.

## Timing
- Pin-to-output latency is 2 cycles for oWR/oX/oY/oR/oG/oB/oSOF.
- oLOCKED rises in the cycle after the qualifying HS fall reaches stage 1. It falls in the cycle after the violation is detected. oWR is 0 from that same cycle.
- A frame whose lock is lost mid-way is truncated and never resumed. After reacquiring, capture restarts at an oSOF.
- Reset values:
  - all outputs 0 (oLOCKED 0, oERR_CNT 0, oH_MEAS/oV_MEAS 0)
  - stage-1 HS/VS regs 1 (no false edge)
  - FSM SEARCH, vs_pend 0
- Reset mid-frame: immediate return to SEARCH. The first measurement after reset is never trusted.
- oERR_CNT holds at 255.

## Configuration
- VGA_RX_CHECKSUM_EN defined:
  - adds oFRAME_SUM (out, 32) and oSUM_VALID (out, 1).
  - Each oWR accumulates R+G+B, zero-extended.
  - At the line-0 HS fall ending a complete LOCKED frame, oFRAME_SUM latches the accumulator and oSUM_VALID pulses 1 cycle later. The accumulator then clears.
  - A lock loss clears the accumulator without a pulse.
- VGA_RX_CHECKSUM_EN undefined: the ports and logic are absent; everything else is identical.

## Structure
- Shared package vga_timing_pkg:
  - 800x480 defaults (H_TOTAL, V_TOTAL, H_START, V_START, H_ACTIVE, V_ACTIVE, HS/VS widths)
  - FSM state encoding (SEARCH, MEASURE, LOCKED)
  - counter widths
- One sub-module vga_rx_edge: stage-1 pin register plus HS/VS fall detect, reused by the capture path.
- FSM, counters and output stage live in the top.

## Test plan
- Nominal 1056x525 source, HS 30 / VS 13 low:
  - oLOCKED rises after the second frame start.
  - each frame gives 384000 oWR, oX 0..799, oY 0..479.
  - exactly one oSOF per frame.
  - oH_MEAS=1056, oV_MEAS=525.
- Pixel value = x[7:0] on R, y[7:0] on G: captured oR==oX[7:0] and oG==oY[7:0] on every oWR. This proves the 2-cycle alignment.
- While locked, shorten one line to 1055 clocks:
  - oLOCKED and oWR drop 1 cycle after that HS fall.
  - oERR_CNT=1.
  - lock returns after 2 good frames.
- Remove HS entirely for 2000 clocks: lock drops when h_cnt reaches 1056, then SEARCH. oH_MEAS keeps its last value.
- Assert iRSTN low mid-frame for 3 cycles: all outputs 0. Relock only after 2 further frame starts. No spurious oSOF.
- With VGA_RX_CHECKSUM_EN and a constant pixel R=G=B=1: oFRAME_SUM=1152000 with an oSUM_VALID pulse every locked frame.
